// File: rtl/plab3_mem_l2_req_arbiter_pkg.sv
// Shared width helpers and the default request message width for the L2 request arbiter.
package plab3_mem_l2_arb_pkg;

   // type(3) + opaque(8) + addr(32) + len(clog2(128/8)=4) + data(128)
   localparam int c_mem_req_nbits = 3 + 8 + 32 + 4 + 128;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int dom_bits(input int n);
      return (n <= 1) ? 1 : clog2(n);
   endfunction

   function automatic int chan_bits(input int n);
      return (n <= 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/plab3_mem_l2_req_arbiter_if.sv
// Request-side and bank-side handshake bundle for the L2 request arbiter.
interface plab3_mem_l2_req_arbiter_if
   import plab3_mem_l2_arb_pkg::*;
#(
   parameter int p_num_chans   = 3,
   parameter int p_msg_nbits   = c_mem_req_nbits,
   parameter int p_num_domains = 2
);
   localparam int DB = dom_bits(p_num_domains);
   localparam int CB = chan_bits(p_num_chans);

   logic [p_num_chans*p_msg_nbits-1:0] in_msg;
   logic [p_num_chans-1:0]             in_val;
   logic [p_num_chans-1:0]             in_rdy;
   logic [p_num_chans*DB-1:0]          in_dom;
   logic [p_msg_nbits-1:0]             out_msg;
   logic                               out_val;
   logic                               out_rdy;
   logic [CB-1:0]                      out_chan;
   logic [DB-1:0]                      out_dom;
   logic [DB-1:0]                      cur_dom;

   modport master (output in_msg, in_val, in_dom, out_rdy,
                   input  in_rdy, out_msg, out_val, out_chan, out_dom, cur_dom);
   modport slave  (input  in_msg, in_val, in_dom, out_rdy,
                   output in_rdy, out_msg, out_val, out_chan, out_dom, cur_dom);
endinterface

// File: rtl/plab3_mem_l2_req_fifo.sv
// Circular per-channel request FIFO; full FIFO never accepts in the cycle it dequeues.
module plab3_mem_l2_req_fifo
   import plab3_mem_l2_arb_pkg::*;
#(
   parameter int p_depth     = 2,
   parameter int p_msg_nbits = c_mem_req_nbits
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enq_val,
   output logic                   enq_rdy,
   input  logic [p_msg_nbits-1:0] enq_msg,
   output logic                   deq_val,
   input  logic                   deq_rdy,
   output logic [p_msg_nbits-1:0] deq_msg
);
   localparam int AW = clog2(p_depth);

   logic [p_msg_nbits-1:0] mem [p_depth];
   logic [AW-1:0]          wr_ptr, rd_ptr;
   logic [AW:0]            count;
   logic                   enq_fire, deq_fire;

   assign enq_rdy  = (count != (AW+1)'(p_depth));
   assign deq_val  = (count != '0);
   assign deq_msg  = mem[rd_ptr];
   assign enq_fire = enq_val && enq_rdy;
   assign deq_fire = deq_val && deq_rdy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
         if (deq_fire) rd_ptr <= rd_ptr + 1'b1;
         if (enq_fire && !deq_fire)      count <= count + 1'b1;
         else if (!enq_fire && deq_fire) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (enq_fire) mem[wr_ptr] <= enq_msg;
   end
endmodule

// File: rtl/plab3_mem_l2_req_arbiter.sv
// N-channel L2 bank request front end: per-channel FIFOs, round-robin grant with lock,
// optional fixed time-slot partitioning by security domain.
module plab3_mem_l2_req_arbiter
   import plab3_mem_l2_arb_pkg::*;
#(
   parameter int p_num_chans   = 3,
   parameter int p_msg_nbits   = c_mem_req_nbits,
   parameter int p_depth       = 2,
   parameter int p_num_domains = 2,
   parameter int p_part_mode   = 0,
   parameter int p_slot_cycles = 32
)(
   input logic clk,
   input logic reset,
   plab3_mem_l2_req_arbiter_if.slave bus
);
   localparam int N  = p_num_chans;
   localparam int W  = p_msg_nbits;
   localparam int DB = dom_bits(p_num_domains);
   localparam int CB = chan_bits(p_num_chans);
   localparam int SB = clog2(p_slot_cycles);

   logic [N-1:0][W-1:0] head;
   logic [N-1:0]        nonempty, fifo_rdy, deq_sel, elig;
   logic [CB-1:0]       rr_ptr, lock_chan, grant;
   logic                lock, found, slot_last, fire;
   logic [SB-1:0]       slot_cnt;
   logic [DB-1:0]       cur_dom;

   for (genvar c = 0; c < N; c++) begin : g_chan
      plab3_mem_l2_req_fifo #(.p_depth(p_depth), .p_msg_nbits(W)) u_fifo (
         .clk     (clk),
         .reset   (reset),
         .enq_val (bus.in_val[c]),
         .enq_rdy (fifo_rdy[c]),
         .enq_msg (bus.in_msg[c*W +: W]),
         .deq_val (nonempty[c]),
         .deq_rdy (deq_sel[c]),
         .deq_msg (head[c])
      );
      assign elig[c]    = nonempty[c] && ((p_part_mode == 0) || (bus.in_dom[c*DB +: DB] == cur_dom));
      assign deq_sel[c] = fire && (grant == CB'(c));
   end

   // A locked grant wins over the round-robin scan so late arrivals cannot steal it.
   always_comb begin
      found = 1'b0;
      grant = '0;
      for (int i = 0; i < N; i++) begin
         if (!found && elig[(int'(rr_ptr) + i) % N]) begin
            found = 1'b1;
            grant = CB'((int'(rr_ptr) + i) % N);
         end
      end
      if (lock) begin
         grant = lock_chan;
         found = elig[lock_chan];
      end
   end

   assign slot_last    = (p_part_mode != 0) && (slot_cnt == SB'(p_slot_cycles - 1));
   assign bus.out_val  = found && !slot_last && !reset;
   assign fire         = bus.out_val && bus.out_rdy;
   assign bus.out_msg  = bus.out_val ? head[grant] : '0;
   assign bus.out_chan = bus.out_val ? grant : '0;
   assign bus.out_dom  = bus.out_val ? bus.in_dom[int'(grant)*DB +: DB] : '0;
   assign bus.in_rdy   = reset ? '0 : fifo_rdy;
   assign bus.cur_dom  = cur_dom;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr    <= '0;
         lock      <= 1'b0;
         lock_chan <= '0;
      end else begin
         if (fire) begin
            rr_ptr <= (grant == CB'(N-1)) ? '0 : grant + 1'b1;
            lock   <= 1'b0;
         end else if (bus.out_val) begin
            lock      <= 1'b1;
            lock_chan <= grant;
         end
         if (slot_last) lock <= 1'b0;
      end
   end

   if (p_part_mode != 0) begin : g_part
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            slot_cnt <= '0;
            cur_dom  <= '0;
         end else if (slot_last) begin
            slot_cnt <= '0;
            cur_dom  <= DB'((int'(cur_dom) + 1) % p_num_domains);
         end else begin
            slot_cnt <= slot_cnt + 1'b1;
         end
      end
   end else begin : g_flat
      assign slot_cnt = '0;
      assign cur_dom  = '0;
   end
endmodule

// File: tb/tb_plab3_mem_l2_req_arbiter.sv
// Bench for the L2 request arbiter: directed vector table, partition and reset sequences,
// then random traffic against a queue-based reference model.
module tb_plab3_mem_l2_req_arbiter;
   import plab3_mem_l2_arb_pkg::*;

   localparam int N = 3;
   localparam int W = c_mem_req_nbits;

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   always #5 clk = ~clk;

   plab3_mem_l2_req_arbiter_if #(.p_num_chans(N), .p_msg_nbits(W), .p_num_domains(2)) bus_a ();
   plab3_mem_l2_req_arbiter_if #(.p_num_chans(N), .p_msg_nbits(W), .p_num_domains(2)) bus_b ();

   plab3_mem_l2_req_arbiter #(.p_num_chans(N), .p_msg_nbits(W), .p_depth(2),
      .p_num_domains(2), .p_part_mode(0), .p_slot_cycles(32)) dut_a (
      .clk(clk), .reset(rst_a), .bus(bus_a.slave));

   plab3_mem_l2_req_arbiter #(.p_num_chans(N), .p_msg_nbits(W), .p_depth(2),
      .p_num_domains(2), .p_part_mode(1), .p_slot_cycles(8)) dut_b (
      .clk(clk), .reset(rst_b), .bus(bus_b.slave));

   typedef struct {
      logic [2:0] val;
      logic       ordy;
      logic       ev;
      logic [1:0] ech;
      int         emi;
      logic [2:0] erdy;
   } vec_t;

   vec_t vq[$];
   int n_pass = 0;
   int n_tot  = 0;

   task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   function automatic logic [W-1:0] mk(input int c, input int i);
      return W'({8'(c), 16'(i)});
   endfunction

   task automatic add(input logic [2:0] v, input logic r, input logic ev, input logic [1:0] ch,
                      input int mi, input logic [2:0] er);
      vec_t t;
      t.val = v; t.ordy = r; t.ev = ev; t.ech = ch; t.emi = mi; t.erdy = er;
      vq.push_back(t);
   endtask

   // reference model state for random traffic
   logic [W-1:0] mq [N][$];
   int  m_rr;
   bit  m_lk;
   int  m_lkc;

   initial begin
      logic [2:0]   erdy;
      logic [W-1:0] rmsg [N];
      bit           ev;
      int           g;

      bus_a.in_val = '0; bus_a.in_msg = '0; bus_a.out_rdy = 1'b0; bus_a.in_dom = 3'b100;
      bus_b.in_val = '0; bus_b.in_msg = '0; bus_b.out_rdy = 1'b0; bus_b.in_dom = 3'b100;

      // values while reset is held
      repeat (2) @(negedge clk);
      bus_a.in_val = 3'b111;
      #1;
      check("rst_in_rdy",   W'(bus_a.in_rdy),   W'(3'b000));
      check("rst_out_val",  W'(bus_a.out_val),  W'(0));
      check("rst_out_msg",  bus_a.out_msg,      '0);
      check("rst_out_chan", W'(bus_a.out_chan), W'(0));
      check("rst_out_dom",  W'(bus_a.out_dom),  W'(0));
      check("rst_cur_dom_b", W'(bus_b.cur_dom), W'(0));
      bus_a.in_val = '0;
      @(negedge clk);
      rst_a = 1'b0;

      // val, ordy, ev, ech, emi, erdy -- one row per cycle
      add(3'b111,1,0,0, 0,3'b111); add(3'b000,1,1,0, 0,3'b111);
      add(3'b000,1,1,1, 0,3'b111); add(3'b000,1,1,2, 0,3'b111);
      add(3'b000,1,0,0, 0,3'b111);
      add(3'b101,1,0,0, 0,3'b111); add(3'b101,1,1,0, 5,3'b111);
      add(3'b101,1,1,2, 5,3'b011); add(3'b101,1,1,0, 6,3'b110);
      add(3'b101,1,1,2, 6,3'b011); add(3'b101,1,1,0, 7,3'b110);
      add(3'b000,1,1,2, 8,3'b011); add(3'b000,1,1,0, 9,3'b111);
      add(3'b000,1,1,2,10,3'b111); add(3'b000,1,0,0, 0,3'b111);
      add(3'b010,0,0,0, 0,3'b111); add(3'b001,0,1,1,15,3'b111);
      add(3'b001,0,1,1,15,3'b111); add(3'b000,0,1,1,15,3'b110);
      add(3'b000,0,1,1,15,3'b110); add(3'b000,0,1,1,15,3'b110);
      add(3'b000,1,1,1,15,3'b110); add(3'b000,1,1,0,16,3'b110);
      add(3'b000,1,1,0,17,3'b111); add(3'b000,1,0,0, 0,3'b111);
      add(3'b001,0,0,0, 0,3'b111); add(3'b001,0,1,0,25,3'b111);
      add(3'b001,0,1,0,25,3'b110); add(3'b001,0,1,0,25,3'b110);
      add(3'b001,1,1,0,25,3'b110); add(3'b001,0,1,0,26,3'b111);
      add(3'b000,0,1,0,26,3'b110); add(3'b000,1,1,0,26,3'b110);
      add(3'b000,1,1,0,30,3'b111); add(3'b000,1,0,0, 0,3'b111);

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         bus_a.in_val  = vq[i].val;
         bus_a.out_rdy = vq[i].ordy;
         for (int c = 0; c < N; c++) bus_a.in_msg[c*W +: W] = mk(c, i);
         #1;
         check($sformatf("v%0d_in_rdy", i),  W'(bus_a.in_rdy),  W'(vq[i].erdy));
         check($sformatf("v%0d_out_val", i), W'(bus_a.out_val), W'(vq[i].ev));
         if (vq[i].ev) begin
            check($sformatf("v%0d_out_chan", i), W'(bus_a.out_chan), W'(vq[i].ech));
            check($sformatf("v%0d_out_msg", i),  bus_a.out_msg, mk(vq[i].ech, vq[i].emi));
         end
      end
      check("mode0_cur_dom", W'(bus_a.cur_dom), W'(0));

      // reset with two queued messages and a locked grant (rr_ptr is 1 here)
      @(negedge clk);
      bus_a.in_val = 3'b011; bus_a.out_rdy = 1'b0;
      @(negedge clk);
      bus_a.in_val = 3'b000;
      #1;
      check("pre_lock_val",  W'(bus_a.out_val),  W'(1));
      check("pre_lock_chan", W'(bus_a.out_chan), W'(1));
      @(negedge clk);
      #1;
      check("locked_chan", W'(bus_a.out_chan), W'(1));
      #2 rst_a = 1'b1;
      #1;
      check("midrst_out_val",  W'(bus_a.out_val),  W'(0));
      check("midrst_in_rdy",   W'(bus_a.in_rdy),   W'(3'b000));
      check("midrst_out_msg",  bus_a.out_msg,      '0);
      check("midrst_out_chan", W'(bus_a.out_chan), W'(0));
      @(negedge clk);
      rst_a = 1'b0;
      bus_a.out_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("postrst%0d_out_val", i), W'(bus_a.out_val), W'(0));
         check($sformatf("postrst%0d_in_rdy", i),  W'(bus_a.in_rdy),  W'(3'b111));
         @(negedge clk);
      end

      // partition mode: ch0 is domain 0, ch2 is domain 1, slots of 8 cycles
      rst_b = 1'b0;
      bus_b.in_val = 3'b101;
      for (int cyc = 0; cyc < 26; cyc++) begin
         int  pos, dom;
         bit  pev;
         pos = cyc % 8;
         dom = (cyc / 8) % 2;
         pev = (cyc >= 1) && (pos != 7);
         bus_b.out_rdy = !(cyc >= 20 && cyc <= 24);
         for (int c = 0; c < N; c++) bus_b.in_msg[c*W +: W] = mk(c, cyc);
         #1;
         check($sformatf("p%0d_cur_dom", cyc), W'(bus_b.cur_dom), W'(dom));
         check($sformatf("p%0d_out_val", cyc), W'(bus_b.out_val), W'(pev));
         if (pev) begin
            check($sformatf("p%0d_out_chan", cyc), W'(bus_b.out_chan), W'(dom == 0 ? 0 : 2));
            check($sformatf("p%0d_out_dom", cyc),  W'(bus_b.out_dom),  W'(dom));
         end
         @(negedge clk);
      end
      bus_b.in_val = '0;

      // random traffic against the queue model; dut_a is freshly reset and idle
      m_rr = 0; m_lk = 0; m_lkc = 0;
      for (int c = 0; c < N; c++) mq[c].delete();
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int c = 0; c < N; c++) begin
            bus_a.in_val[c] = ($urandom_range(0, 9) < 6);
            rmsg[c] = W'({$urandom, $urandom, $urandom});
            bus_a.in_msg[c*W +: W] = rmsg[c];
         end
         bus_a.out_rdy = ($urandom_range(0, 9) < 7);
         #1;
         for (int c = 0; c < N; c++) erdy[c] = (mq[c].size() != 2);
         ev = 0; g = 0;
         if (m_lk) begin
            ev = 1; g = m_lkc;
         end else begin
            for (int i = 0; i < N; i++)
               if (!ev && mq[(m_rr + i) % N].size() > 0) begin
                  ev = 1; g = (m_rr + i) % N;
               end
         end
         check($sformatf("r%0d_in_rdy", cyc),  W'(bus_a.in_rdy),  W'(erdy));
         check($sformatf("r%0d_out_val", cyc), W'(bus_a.out_val), W'(ev));
         if (ev) begin
            check($sformatf("r%0d_out_chan", cyc), W'(bus_a.out_chan), W'(g));
            check($sformatf("r%0d_out_msg", cyc),  bus_a.out_msg, mq[g][0]);
         end
         if (ev && bus_a.out_rdy) begin
            void'(mq[g].pop_front());
            m_rr = (g + 1) % N;
            m_lk = 0;
         end else if (ev) begin
            m_lk = 1; m_lkc = g;
         end
         for (int c = 0; c < N; c++)
            if (bus_a.in_val[c] && erdy[c]) mq[c].push_back(rmsg[c]);
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
